piso_serializer: RTL



---
 rtl/piso_serializer.sv | 123 ++++++++++++
 1 files changed

// File: rtl/piso_serializer.sv
// Parallel-in/serial-out stage: accepts a word over valid/ready, emits it one bit
// per clock with a frame qualifier, optional even parity and an idle gap afterwards.
module piso_serializer #(
    parameter int WIDTH      = 8,
    parameter int MSB_FIRST  = 0,
    parameter int PARITY_EN  = 0,
    parameter int GAP_CYCLES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             data_out,
    output logic             frame,
    output logic             done
);

    localparam int N     = WIDTH + ((PARITY_EN != 0) ? 1 : 0);
    localparam int CNT_W = $clog2(N);
    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        GAP   = 2'd2
    } state_t;

    state_t           state_q;
    logic [N-1:0]     sreg_q;
    logic [CNT_W-1:0] bit_cnt_q;
    logic [GAP_W-1:0] gap_cnt_q;
    logic             in_ready_q;
    logic             data_out_q;
    logic             frame_q;
    logic             done_q;
    logic [N-1:0]     word_d;

    // Reorders the word into transmit order (bit 0 goes out first) and appends parity.
    function automatic logic [N-1:0] order_bits(input logic [WIDTH-1:0] w);
        logic [N-1:0] v;
        v = '0;
        for (int j = 0; j < WIDTH; j++) begin
            v[j] = (MSB_FIRST != 0) ? w[WIDTH-1-j] : w[j];
        end
        if (PARITY_EN != 0) begin
            v[N-1] = ^w;
        end
        return v;
    endfunction

    always_comb begin
        word_d = order_bits(in_data);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            sreg_q     <= '0;
            bit_cnt_q  <= '0;
            gap_cnt_q  <= '0;
            in_ready_q <= 1'b0;
            data_out_q <= 1'b0;
            frame_q    <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    in_ready_q <= 1'b1;
                    done_q     <= 1'b0;
                    if (in_valid && in_ready_q) begin
                        state_q    <= SHIFT;
                        in_ready_q <= 1'b0;
                        frame_q    <= 1'b1;
                        data_out_q <= word_d[0];
                        sreg_q     <= word_d >> 1;
                        bit_cnt_q  <= CNT_W'(N - 1);
                    end
                end
                SHIFT: begin
                    if (bit_cnt_q == '0) begin
                        frame_q    <= 1'b0;
                        data_out_q <= 1'b0;
                        done_q     <= 1'b1;
                        if (GAP_CYCLES == 0) begin
                            state_q    <= IDLE;
                            in_ready_q <= 1'b1;
                        end else begin
                            state_q   <= GAP;
                            gap_cnt_q <= GAP_W'(GAP_CYCLES - 1);
                        end
                    end else begin
                        data_out_q <= sreg_q[0];
                        sreg_q     <= sreg_q >> 1;
                        bit_cnt_q  <= bit_cnt_q - CNT_W'(1);
                    end
                end
                GAP: begin
                    done_q <= 1'b0;
                    if (gap_cnt_q == '0) begin
                        state_q    <= IDLE;
                        in_ready_q <= 1'b1;
                    end else begin
                        gap_cnt_q <= gap_cnt_q - GAP_W'(1);
                    end
                end
                default: begin
                    state_q    <= IDLE;
                    in_ready_q <= 1'b0;
                    frame_q    <= 1'b0;
                    data_out_q <= 1'b0;
                    done_q     <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready = in_ready_q;
    assign data_out = data_out_q;
    assign frame    = frame_q;
    assign done     = done_q;

endmodule
